// File: rtl/alu_decode_stage.sv
// alu_decode_stage
// Issue stage in front of the ALU. Accepts one RV32I instruction word per
// valid/ready handshake, decodes OP and OP-IMM, reads operands from a
// 32-entry register file (with optional same-cycle writeback forwarding)
// and presents a registered operation to the ALU. Everything else is
// flagged illegal but still handed over so the consumer can trap on it.

module alu_decode_stage #(
  parameter int XLEN      = 32,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,

  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rd,
  output logic            out_illegal,

  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  // One decoded operation as it sits in the output register.
  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic            illegal;
  } issue_op_t;

  // Instruction fields
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign funct7 = in_instr[31:25];
  assign imm    = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};

  // Handshake
  logic accept;
  logic transfer;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign transfer = out_valid && out_ready;

  // Register file
  logic [XLEN-1:0] rf [32];

  // Register file write port; x0 is never written so it stays zero.
  always_ff @(posedge clk) begin
    // NOTE: the whole array must clear in one reset cycle, so it is built
    // from resettable flops; a RAM macro could not honour that.
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        rf[i] <= '0;
      end
    end else if (wb_en && (wb_rd != 5'd0)) begin
      rf[wb_rd] <= wb_data;
    end
  end

  // Source operand reads, optionally forwarding a writeback landing in
  // the same cycle so the captured value is the post-write one.
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;

  // Read port 1 (rs1) with x0 hardwired to zero and optional forwarding.
  always_comb begin
    src1 = '0;
    if (rs1 != 5'd0) begin
      if (WB_BYPASS && wb_en && (wb_rd == rs1)) begin
        src1 = wb_data;
      end else begin
        src1 = rf[rs1];
      end
    end
  end

  // Read port 2 (rs2) with x0 hardwired to zero and optional forwarding.
  always_comb begin
    src2 = '0;
    if (rs2 != 5'd0) begin
      if (WB_BYPASS && wb_en && (wb_rd == rs2)) begin
        src2 = wb_data;
      end else begin
        src2 = rf[rs2];
      end
    end
  end

  // Decode
  logic      legal;
  issue_op_t dec;

  // Legality and funct7 selection; illegal words are zeroed except opcode.
  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    legal       = 1'b0;
    dec         = '0;
    dec.opcode  = opcode;

    unique case (opcode)
      OPC_OP: begin
        legal = (funct7 == F7_ZERO) ||
                ((funct7 == F7_ALT) &&
                 ((funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA)));
        dec.b      = src2;
        dec.funct7 = funct7;
      end
      OPC_OP_IMM: begin
        dec.b = imm;
        unique case (funct3)
          F3_SLL: begin
            legal      = (funct7 == F7_ZERO);
            dec.funct7 = funct7;
          end
          F3_SRL_SRA: begin
            legal      = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
            dec.funct7 = funct7;
          end
          default: begin
            // The upper immediate bits are data here, not a funct7.
            legal      = 1'b1;
            dec.funct7 = F7_ZERO;
          end
        endcase
      end
      default: begin
        legal = 1'b0;
      end
    endcase

    if (legal) begin
      dec.a       = src1;
      dec.funct3  = funct3;
      dec.rd      = rd;
      dec.illegal = 1'b0;
    end else begin
      dec.a       = '0;
      dec.b       = '0;
      dec.funct3  = '0;
      dec.funct7  = '0;
      dec.rd      = '0;
      dec.illegal = 1'b1;
    end
  end

  // Output stage
  issue_op_t held;

  // Output register: load on accept, clear valid on a bare transfer, and
  // otherwise hold so the ALU sees stable fields while stalled.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      out_valid <= 1'b0;
      held      <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      held      <= dec;
    end else if (transfer) begin
      out_valid <= 1'b0;
    end
  end

  assign out_a       = held.a;
  assign out_b       = held.b;
  assign out_opcode  = held.opcode;
  assign out_funct3  = held.funct3;
  assign out_funct7  = held.funct7;
  assign out_rd      = held.rd;
  assign out_illegal = held.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage. A behavioural model derived from
// the decode rules tracks the expected output register every cycle; a
// compare process checks the DUT against it on each falling edge, and the
// directed sequence pins key results with hand-computed literals.

module tb_alu_decode_stage;

  localparam bit BYPASS = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [4:0]  out_rd;
  logic        out_illegal;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  alu_decode_stage #(.XLEN(32), .WB_BYPASS(BYPASS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_opcode (out_opcode),
    .out_funct3 (out_funct3),
    .out_funct7 (out_funct7),
    .out_rd     (out_rd),
    .out_illegal(out_illegal),
    .wb_en      (wb_en),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic        illegal;
  } exp_t;

  logic [31:0] m_rf [32];
  logic        m_valid = 1'b0;
  exp_t        m_op;

  function automatic logic [31:0] model_src(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (BYPASS && wb_en && wb_rd == r) return wb_data;
    return m_rf[r];
  endfunction

  function automatic exp_t model_decode(input logic [31:0] ins);
    exp_t        e;
    logic [6:0]  f7  = ins[31:25];
    logic [2:0]  f3  = ins[14:12];
    logic [31:0] imm = {{20{ins[31]}}, ins[31:20]};
    bit          ok  = 0;
    e.opcode = ins[6:0];
    e.a      = model_src(ins[19:15]);
    e.funct3 = f3;
    e.rd     = ins[11:7];
    e.b      = 0;
    e.funct7 = 0;
    if (ins[6:0] == 7'h33) begin
      ok       = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      e.b      = model_src(ins[24:20]);
      e.funct7 = f7;
    end else if (ins[6:0] == 7'h13) begin
      e.b = imm;
      if (f3 == 3'd1) begin
        ok = (f7 == 7'h00);  e.funct7 = f7;
      end else if (f3 == 3'd5) begin
        ok = (f7 == 7'h00 || f7 == 7'h20);  e.funct7 = f7;
      end else begin
        ok = 1;  e.funct7 = 7'h00;
      end
    end
    e.illegal = !ok;
    if (!ok) begin
      e.a = 0; e.b = 0; e.funct3 = 0; e.funct7 = 0; e.rd = 0;
    end
    return e;
  endfunction

  // Model update at each rising edge from the inputs present before it.
  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b0;
      m_op    = '{default: '0};
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    end else begin
      if (in_valid && (!m_valid || out_ready)) begin
        m_op    = model_decode(in_instr);
        m_valid = 1'b1;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      if (wb_en && wb_rd != 0) m_rf[wb_rd] = wb_data;
    end
  end

  // Compare DUT with the model every falling edge.
  always @(negedge clk) begin
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
    if (m_valid) begin
      check("out_a", out_a, m_op.a);
      check("out_b", out_b, m_op.b);
      check("out_opcode", {25'd0, out_opcode}, {25'd0, m_op.opcode});
      check("out_funct3", {29'd0, out_funct3}, {29'd0, m_op.funct3});
      check("out_funct7", {25'd0, out_funct7}, {25'd0, m_op.funct7});
      check("out_rd", {27'd0, out_rd}, {27'd0, m_op.rd});
      check("out_illegal", {31'd0, out_illegal}, {31'd0, m_op.illegal});
    end
  end

  // Directed stimulus
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins);
    in_instr = ins;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  localparam logic [31:0] I_NOP   = 32'h0000_0013;
  localparam logic [31:0] I_ADD   = 32'h0020_81B3;
  localparam logic [31:0] I_SUB   = 32'h4020_81B3;
  localparam logic [31:0] I_SRAI  = 32'h4030_D193;
  localparam logic [31:0] I_ADDI  = 32'hFFF0_8193;
  localparam logic [31:0] I_ANDI  = 32'hFFF0_F193;
  localparam logic [31:0] I_ADD0  = 32'h0000_01B3;
  localparam logic [31:0] I_LW    = 32'h0040_A183;
  localparam logic [31:0] I_SLLX  = 32'h4020_91B3;
  localparam logic [31:0] I_SLLIX = 32'h4030_9193;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b1;
    wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    step(); step();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_a", out_a, 32'd0);
    check("rst_illegal", {31'd0, out_illegal}, 32'd0);
    rst = 1'b0;

    issue(I_NOP);
    check("nop_valid", {31'd0, out_valid}, 32'd1);
    check("nop_a", out_a, 32'd0);
    check("nop_b", out_b, 32'd0);
    check("nop_f7", {25'd0, out_funct7}, 32'd0);
    check("nop_ill", {31'd0, out_illegal}, 32'd0);

    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'hFFFF_FFFF; step();
    wb_rd = 5'd2; wb_data = 32'h0000_10E3; step();
    wb_en = 1'b0;

    issue(I_ADD);
    check("add_a", out_a, 32'hFFFF_FFFF);
    check("add_b", out_b, 32'h0000_10E3);
    check("add_f3", {29'd0, out_funct3}, 32'd0);
    check("add_f7", {25'd0, out_funct7}, 32'd0);
    check("add_rd", {27'd0, out_rd}, 32'd3);
    issue(I_SUB);
    check("sub_f7", {25'd0, out_funct7}, 32'h20);
    issue(I_SRAI);
    check("srai_f3", {29'd0, out_funct3}, 32'd5);
    check("srai_f7", {25'd0, out_funct7}, 32'h20);
    check("srai_shamt", {27'd0, out_b[4:0]}, 32'd3);
    issue(I_ADDI);
    check("addi_b", out_b, 32'hFFFF_FFFF);
    check("addi_f7", {25'd0, out_funct7}, 32'd0);
    issue(I_ANDI);
    check("andi_f7", {25'd0, out_funct7}, 32'd0);
    check("andi_b", out_b, 32'hFFFF_FFFF);
    step();

    // Stall with a pending instruction, then release.
    out_ready = 1'b0;
    issue(I_ADD);
    in_instr = I_SUB; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_a", out_a, 32'hFFFF_FFFF);
      check("stall_f7", {25'd0, out_funct7}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("b2b_sub_f7", {25'd0, out_funct7}, 32'h20);
    in_instr = I_SRAI; step();
    check("b2b_srai_f3", {29'd0, out_funct3}, 32'd5);
    in_instr = I_ADDI; step();
    check("b2b_addi_b", out_b, 32'hFFFF_FFFF);
    in_valid = 1'b0;
    step();

    // Writeback forwarding into the captured operands.
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h5;
    issue(I_ADD);
    check("byp_a", out_a, 32'h5);
    check("byp_b", out_b, 32'h0000_10E3);
    wb_rd = 5'd0; wb_data = 32'h77;
    issue(I_ADD);
    check("byp_x0_a", out_a, 32'h5);
    wb_rd = 5'd2; wb_data = 32'h1234;
    issue(I_ADD);
    check("byp_rs2_b", out_b, 32'h1234);
    wb_en = 1'b0;
    issue(I_ADD0);
    check("x0_a", out_a, 32'd0);
    check("x0_b", out_b, 32'd0);

    // Illegal encodings are still handed over, zeroed.
    issue(I_LW);
    check("lw_ill", {31'd0, out_illegal}, 32'd1);
    check("lw_opc", {25'd0, out_opcode}, 32'h03);
    check("lw_a", out_a, 32'd0);
    check("lw_rd", {27'd0, out_rd}, 32'd0);
    issue(I_SLLX);
    check("sllx_ill", {31'd0, out_illegal}, 32'd1);
    check("sllx_opc", {25'd0, out_opcode}, 32'h33);
    check("sllx_b", out_b, 32'd0);
    check("sllx_f7", {25'd0, out_funct7}, 32'd0);
    issue(I_SLLIX);
    check("sllix_ill", {31'd0, out_illegal}, 32'd1);

    // Reset with an operation held; writeback during reset is ignored.
    out_ready = 1'b0;
    issue(I_ADD);
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1; wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h9;
    in_valid = 1'b1; in_instr = I_ADD;
    step();
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_a", out_a, 32'd0);
    rst = 1'b0; wb_en = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    issue(I_ADD);
    check("post_rst_valid", {31'd0, out_valid}, 32'd1);
    check("post_rst_a", out_a, 32'd0);
    check("post_rst_b", out_b, 32'd0);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
